// File: rtl/ushift_register.sv
// Universal shift register: parallel load, runtime shift direction, serial out,
// and a framing counter that strobes o_full once every BITS shifts.
module ushift_register #(
  parameter int              BITS    = 8,
  parameter logic [BITS-1:0] RST_VAL = '0,
  localparam int             CW      = $clog2(BITS)
) (
  input  logic            clk,
  input  logic            i_aclr,
  input  logic            i_sclr,
  input  logic            i_en,
  input  logic            i_load,
  input  logic [BITS-1:0] i_pdata,
  input  logic            i_dir,
  input  logic            i_dat,
  output logic [BITS-1:0] o_data,
  output logic            o_sdat,
  output logic [CW-1:0]   o_cnt,
  output logic            o_full
);

  localparam logic [CW-1:0] CNT_MAX = CW'(BITS - 1);

  logic [BITS-1:0] r_data;
  logic [CW-1:0]   r_cnt;
  logic            r_full;
  logic [BITS-1:0] w_shifted;

  // Serial data only feeds the register contents, never the counter or strobe.
  assign w_shifted = i_dir ? {i_dat, r_data[BITS-1:1]} : {r_data[BITS-2:0], i_dat};

  always_ff @(posedge clk or posedge i_aclr) begin
    if (i_aclr) begin
      r_data <= RST_VAL;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (i_sclr) begin
      r_data <= RST_VAL;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_pdata;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (i_en) begin
      r_data <= w_shifted;
      if (r_cnt == CNT_MAX) begin
        r_cnt  <= '0;
        r_full <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_full <= 1'b0;
      end
    end else begin
      r_full <= 1'b0;
    end
  end

  // The bit that the next shift would eject, tracking i_dir even during reset.
  assign o_sdat = i_dir ? r_data[0] : r_data[BITS-1];
  assign o_data = r_data;
  assign o_cnt  = r_cnt;
  assign o_full = r_full;

endmodule

// File: tb/tb_ushift_register.sv
// Scoreboard bench for ushift_register (BITS=5): the driver pushes the expected
// post-edge state from an arithmetic reference model; a monitor pops and compares.
module tb_ushift_register;

  localparam int BITS = 5;
  localparam int CW   = $clog2(BITS);

  typedef struct packed {
    logic [BITS-1:0] data;
    logic [CW-1:0]   cnt;
    logic            full;
  } expect_t;

  logic            clk = 1'b0;
  logic            i_aclr = 1'b1;
  logic            i_sclr = 1'b0;
  logic            i_en = 1'b0;
  logic            i_load = 1'b0;
  logic [BITS-1:0] i_pdata = '0;
  logic            i_dir = 1'b0;
  logic            i_dat = 1'b0;
  logic [BITS-1:0] o_data;
  logic            o_sdat;
  logic [CW-1:0]   o_cnt;
  logic            o_full;

  int      nChecks = 0;
  int      nFails = 0;
  int      nPushed = 0;
  int      nPopped = 0;
  expect_t expQ[$];

  // Reference model state: the word as an integer and the number of shifts in the current frame.
  int modelWord = 0;
  int modelShifts = 0;
  int modelFull = 0;

  ushift_register #(.BITS(BITS), .RST_VAL(5'b00000)) dut (
    .clk(clk), .i_aclr(i_aclr), .i_sclr(i_sclr), .i_en(i_en), .i_load(i_load),
    .i_pdata(i_pdata), .i_dir(i_dir), .i_dat(i_dat),
    .o_data(o_data), .o_sdat(o_sdat), .o_cnt(o_cnt), .o_full(o_full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void pushExpected();
    expect_t e;
    e.data = modelWord[BITS-1:0];
    e.cnt  = modelShifts[CW-1:0];
    e.full = modelFull[0];
    expQ.push_back(e);
    nPushed++;
  endfunction

  // Drive one cycle of inputs at the falling edge, check the serial output, then advance the model.
  task automatic applyStimulus(input bit sclr, input bit load, input bit en,
                               input int pdata, input bit dir, input bit dat);
    int sdatExp;
    @(negedge clk);
    i_sclr = sclr; i_load = load; i_en = en;
    i_pdata = pdata[BITS-1:0]; i_dir = dir; i_dat = dat;
    sdatExp = dir ? (modelWord % 2) : (modelWord / (1 << (BITS-1))) % 2;
    #1 checkOutput("sdat", int'(o_sdat), sdatExp);
    modelFull = 0;
    if (sclr) begin
      modelWord = 0;
      modelShifts = 0;
    end else if (load) begin
      modelWord = pdata % (1 << BITS);
      modelShifts = 0;
    end else if (en) begin
      if (dir) modelWord = modelWord / 2 + int'(dat) * (1 << (BITS-1));
      else     modelWord = (modelWord * 2 + int'(dat)) % (1 << BITS);
      modelShifts = modelShifts + 1;
      if (modelShifts == BITS) begin
        modelShifts = 0;
        modelFull = 1;
      end
    end
    pushExpected();
  endtask

  task automatic shiftBit(input bit dir, input bit dat);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, dir, dat);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Pulse the asynchronous clear between edges and check it acts before the next edge.
  task automatic pulseReset();
    @(negedge clk);
    i_sclr = 1'b0; i_load = 1'b0; i_en = 1'b0;
    #2 i_aclr = 1'b1;
    #1;
    checkOutput("aclr_data", int'(o_data), 0);
    checkOutput("aclr_cnt", int'(o_cnt), 0);
    checkOutput("aclr_full", int'(o_full), 0);
    checkOutput("aclr_sdat", int'(o_sdat), 0);
    #1 i_aclr = 1'b0;
    modelWord = 0;
    modelShifts = 0;
    modelFull = 0;
    pushExpected();
  endtask

  // Monitor: every rising edge is an output event for this block.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        nPopped++;
        checkOutput("data", int'(o_data), int'(e.data));
        checkOutput("cnt", int'(o_cnt), int'(e.cnt));
        checkOutput("full", int'(o_full), int'(e.full));
      end
    end
  end

  initial begin
    bit sclr, load, en, dir, dat;
    int pdata;

    repeat (2) @(negedge clk);
    i_aclr = 1'b0;
    idle();

    // Shift in 1,0,1,1,1 toward the MSB, then an async pulse mid-stream.
    shiftBit(1'b0, 1'b1); shiftBit(1'b0, 1'b0); shiftBit(1'b0, 1'b1);
    shiftBit(1'b0, 1'b1); shiftBit(1'b0, 1'b1);
    shiftBit(1'b0, 1'b1); shiftBit(1'b0, 1'b0);
    pulseReset();

    // Serialise 10110 out of the MSB end.
    applyStimulus(1'b0, 1'b1, 1'b0, 5'b10110, 1'b0, 1'b0);
    repeat (5) shiftBit(1'b0, 1'b0);

    // Right shifts from zero, then a direction change mid-word.
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    shiftBit(1'b1, 1'b1); shiftBit(1'b1, 1'b1); shiftBit(1'b1, 1'b0);
    shiftBit(1'b0, 1'b1);

    // Load beats enable at cnt=3; clear beats load.
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    repeat (3) shiftBit(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'b01010, 1'b0, 1'b1);
    repeat (2) shiftBit(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 5'b01010, 1'b0, 1'b1);

    // Stall then wrap twice: 3 shifts, 4 idle, 7 shifts.
    repeat (3) shiftBit(1'b0, 1'b1);
    repeat (4) idle();
    repeat (7) shiftBit(1'b1, 1'b0);
    idle();

    // Randomised traffic with occasional asynchronous clears.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulseReset();
      end else begin
        sclr  = ($urandom_range(0, 29) == 0);
        load  = ($urandom_range(0, 11) == 0);
        en    = ($urandom_range(0, 9) < 7);
        dir   = 1'($urandom);
        dat   = 1'($urandom);
        pdata = int'($urandom_range(0, (1 << BITS) - 1));
        applyStimulus(sclr, load, en, pdata, dir, dat);
      end
    end

    idle();
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", nPopped, nPushed);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
